// File: rtl/i2c_client_arbiter_if.sv
// Bus bundle between the per-device I2C client routines, the client arbiter
// and the single-port I2C core. The slave modport is the arbiter's view:
// it receives client requests and drives the core. The master modport is the
// view of the surrounding logic, which issues client requests and plays the core.
interface i2c_client_arbiter_if #(
   parameter int NUM_CLIENTS = 2,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16
);

   // Client side
   logic [NUM_CLIENTS-1:0]                 cl_read_i;
   logic [NUM_CLIENTS-1:0]                 cl_write_i;
   logic [NUM_CLIENTS-1:0]                 cl_lock_i;
   logic [NUM_CLIENTS-1:0][ADDR_WIDTH-1:0] cl_address_i;
   logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] cl_writedata_i;
   logic [NUM_CLIENTS-1:0]                 cl_waitrequest_o;
   logic [DATA_WIDTH-1:0]                  cl_readdata_o;
   logic [NUM_CLIENTS-1:0]                 cl_readdatavalid_o;
   logic [NUM_CLIENTS-1:0]                 cl_timeout_err_o;
   logic [NUM_CLIENTS-1:0]                 err_clear_i;

   // Core side
   logic                                   m_read_o;
   logic                                   m_write_o;
   logic [ADDR_WIDTH-1:0]                  m_address_o;
   logic [DATA_WIDTH-1:0]                  m_writedata_o;
   logic                                   m_waitrequest_i;
   logic [DATA_WIDTH-1:0]                  m_readdata_i;
   logic                                   m_readdatavalid_i;

   modport slave (
      input  cl_read_i, cl_write_i, cl_lock_i, cl_address_i, cl_writedata_i, err_clear_i,
      output cl_waitrequest_o, cl_readdata_o, cl_readdatavalid_o, cl_timeout_err_o,
      output m_read_o, m_write_o, m_address_o, m_writedata_o,
      input  m_waitrequest_i, m_readdata_i, m_readdatavalid_i
   );

   modport master (
      output cl_read_i, cl_write_i, cl_lock_i, cl_address_i, cl_writedata_i, err_clear_i,
      input  cl_waitrequest_o, cl_readdata_o, cl_readdatavalid_o, cl_timeout_err_o,
      input  m_read_o, m_write_o, m_address_o, m_writedata_o,
      output m_waitrequest_i, m_readdata_i, m_readdatavalid_i
   );

endinterface

// File: rtl/i2c_client_arbiter.sv
// N-client Avalon-MM arbiter in front of the single-port I2C core.
// Round-robin grant, optional per-client lock so a client can chain a
// read-modify-write sequence, read-response routing back to the granted
// client, and a read timeout that answers with zero data plus a sticky
// per-client error flag when the core never responds.
module i2c_client_arbiter #(
   parameter int NUM_CLIENTS       = 2,
   parameter int DATA_WIDTH        = 16,
   parameter int ADDR_WIDTH        = 16,
   parameter int RD_TIMEOUT_CYCLES = 65535
) (
   input  logic                clk_i,
   input  logic                srst_i,
   i2c_client_arbiter_if.slave bus
);

   localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int CW = (RD_TIMEOUT_CYCLES > 1) ? $clog2(RD_TIMEOUT_CYCLES + 1) : 1;
   localparam logic [GW-1:0] LAST_CLIENT = GW'(NUM_CLIENTS - 1);
   // The counter starts at zero on read acceptance, so the timeout fires on
   // the RD_TIMEOUT_CYCLES-th cycle spent waiting.
   localparam logic [CW-1:0] TMO_LAST = CW'((RD_TIMEOUT_CYCLES > 0) ? RD_TIMEOUT_CYCLES - 1 : 0);
   localparam bit            TMO_EN   = (RD_TIMEOUT_CYCLES > 0);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_FWD    = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;

   logic [1:0]             state;
   logic [GW-1:0]          grant;
   logic [GW-1:0]          last_grant;
   logic [GW-1:0]          next_grant;
   logic [CW-1:0]          tmo_cnt;
   logic [NUM_CLIENTS-1:0] req;
   logic [NUM_CLIENTS-1:0] grant_onehot;
   logic [NUM_CLIENTS-1:0] err_set;
   logic                   any_req;
   logic                   gnt_req;
   logic                   gnt_write;
   logic                   gnt_lock;
   logic                   accept;
   logic                   tmo_hit;
   logic [ADDR_WIDTH-1:0]  sel_address;
   logic [DATA_WIDTH-1:0]  sel_writedata;
   int                     scan_idx;

   // A client with read and write both raised is serviced as a write.
   assign req          = bus.cl_read_i | bus.cl_write_i;
   assign gnt_req      = req[grant];
   assign gnt_write    = bus.cl_write_i[grant];
   assign gnt_lock     = bus.cl_lock_i[grant];
   assign grant_onehot = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << grant;
   assign accept       = (state == ST_FWD) && gnt_req && !bus.m_waitrequest_i;
   assign tmo_hit      = TMO_EN && (state == ST_RDWAIT) && (tmo_cnt == TMO_LAST);

   assign sel_address       = bus.cl_address_i[grant];
   assign sel_writedata     = bus.cl_writedata_i[grant];
   assign bus.m_address_o   = sel_address;
   assign bus.m_writedata_o = sel_writedata;

   // Round-robin search starting just after the last completed grant.
   always_comb begin
      next_grant = last_grant;
      any_req    = 1'b0;
      scan_idx   = 0;
      for (int k = 1; k <= NUM_CLIENTS; k++) begin
         scan_idx = int'(last_grant) + k;
         if (scan_idx >= NUM_CLIENTS) begin
            scan_idx = scan_idx - NUM_CLIENTS;
         end
         if (!any_req && req[scan_idx]) begin
            any_req    = 1'b1;
            next_grant = GW'(scan_idx);
         end
      end
   end

   // Forward the granted client's command to the core only while in FWD.
   always_comb begin
      bus.m_read_o         = 1'b0;
      bus.m_write_o        = 1'b0;
      bus.cl_waitrequest_o = '1;
      if (state == ST_FWD) begin
         bus.m_write_o               = gnt_write;
         bus.m_read_o                = bus.cl_read_i[grant] & ~gnt_write;
         bus.cl_waitrequest_o[grant] = bus.m_waitrequest_i;
      end
   end

   // A timeout only flags an error when no real response arrives that cycle.
   always_comb begin
      err_set = '0;
      if (tmo_hit && !bus.m_readdatavalid_i) begin
         err_set = grant_onehot;
      end
   end

   // Arbitration FSM, response routing, timeout counter and error flags.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state                  <= ST_IDLE;
         grant                  <= '0;
         last_grant             <= LAST_CLIENT;
         tmo_cnt                <= '0;
         bus.cl_readdata_o      <= {DATA_WIDTH{1'b0}};
         bus.cl_readdatavalid_o <= '0;
         bus.cl_timeout_err_o   <= '0;
      end else begin
         bus.cl_readdatavalid_o <= '0;
         bus.cl_timeout_err_o   <= (bus.cl_timeout_err_o & ~bus.err_clear_i) | err_set;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  grant <= next_grant;
                  state <= ST_FWD;
               end
            end
            ST_FWD: begin
               if (!gnt_req) begin
                  state <= ST_IDLE;
               end else if (accept) begin
                  if (gnt_write) begin
                     if (!gnt_lock) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                     end
                  end else begin
                     tmo_cnt <= '0;
                     state   <= ST_RDWAIT;
                  end
               end
            end
            ST_RDWAIT: begin
               tmo_cnt <= tmo_cnt + CW'(1);
               if (bus.m_readdatavalid_i || tmo_hit) begin
                  bus.cl_readdata_o      <= bus.m_readdatavalid_i ? bus.m_readdata_i : {DATA_WIDTH{1'b0}};
                  bus.cl_readdatavalid_o <= grant_onehot;
                  if (gnt_lock) begin
                     state <= ST_FWD;
                  end else begin
                     last_grant <= grant;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/i2c_client_arbiter.md
Name: i2c_client_arbiter

Overview:
- N-client Avalon-MM arbiter in front of the single-port I2C core; replaces the fixed two-client (codec/ADC) arrangement with a parametrised client count.
- Round-robin fairness, optional per-client bus lock for multi-transaction sequences, read-response routing, and a read timeout with per-client error flags.
- Sits between the per-device I2C routines and the I2C core inside the I2C subsystem.

Parameters:
- NUM_CLIENTS, 2, number of client ports (2..8).
- DATA_WIDTH, 16, readdata/writedata width.
- ADDR_WIDTH, 16, address width.
- RD_TIMEOUT_CYCLES, 65535, maximum cycles to wait for core readdatavalid after read acceptance; 0 disables the timeout.

Ports:
- clk_i  in  1  system clock
- srst_i  in  1  synchronous active-high reset
- cl_read_i  in  NUM_CLIENTS  per-client read request
- cl_write_i  in  NUM_CLIENTS  per-client write request
- cl_lock_i  in  NUM_CLIENTS  hold grant after current transaction
- cl_address_i  in  NUM_CLIENTS x ADDR_WIDTH  per-client address
- cl_writedata_i  in  NUM_CLIENTS x DATA_WIDTH  per-client write data
- cl_waitrequest_o  out  NUM_CLIENTS  per-client waitrequest
- cl_readdata_o  out  DATA_WIDTH  shared read data, qualified per client
- cl_readdatavalid_o  out  NUM_CLIENTS  per-client read-data strobe
- cl_timeout_err_o  out  NUM_CLIENTS  sticky read-timeout flag per client
- err_clear_i  in  NUM_CLIENTS  clear matching timeout flag
- m_read_o / m_write_o  out  1  to I2C core
- m_address_o  out  ADDR_WIDTH  to core
- m_writedata_o  out  DATA_WIDTH  to core
- m_waitrequest_i  in  1  from core
- m_readdata_i  in  DATA_WIDTH  from core
- m_readdatavalid_i  in  1  from core

Behaviour:
- Clock/reset: one clock clk_i; srst_i synchronous, active-high.
- Reset values:
  - cl_waitrequest_o all 1; cl_readdatavalid_o 0; cl_readdata_o 0; cl_timeout_err_o 0.
  - m_read_o and m_write_o 0; state IDLE; last_grant = NUM_CLIENTS-1, so client 0 has first priority.
- Request: req[i] = cl_read_i[i] | cl_write_i[i]. Read and write asserted together on one client is treated as a write.
- State IDLE:
  - All cl_waitrequest_o = 1, m_read_o/m_write_o = 0.
  - On any req, grant the first requester searching from last_grant+1 with wrap-around; register grant; go to FWD.
  - Arbitration takes 1 cycle, so the command reaches the core 1 cycle after the request is first seen in IDLE.
- State FWD:
  - m_* = granted client's command, address and data (combinational mux on the registered grant).
  - cl_waitrequest_o[grant] = m_waitrequest_i; all other clients 1.
  - Acceptance = (m_read_o | m_write_o) & !m_waitrequest_i.
  - On an accepted write: if cl_lock_i[grant], stay in FWD with the same grant; otherwise last_grant <= grant and go to IDLE.
  - On an accepted read: go to RDWAIT and clear the timeout counter.
  - If the granted client drops req before acceptance (protocol violation), return to IDLE without updating last_grant.
- State RDWAIT:
  - m_read_o/m_write_o = 0; all cl_waitrequest_o = 1.
  - On m_readdatavalid_i: cl_readdata_o <= m_readdata_i and cl_readdatavalid_o[grant] pulses for 1 cycle (registered, 1 cycle after the core strobe). Then go to FWD if cl_lock_i[grant], else update last_grant and go to IDLE.
  - Timeout counter increments each cycle in RDWAIT. When it reaches RD_TIMEOUT_CYCLES (and the parameter is non-zero):
    - cl_readdata_o <= 0, pulse cl_readdatavalid_o[grant], set cl_timeout_err_o[grant];
    - leave RDWAIT exactly as on a valid response.
  - Valid and timeout in the same cycle: valid wins, no error.
  - A readdatavalid arriving outside RDWAIT is dropped.
- Lock: held grant persists while cl_lock_i[grant] = 1 at each completion. Other clients starve during lock, which is intentional for register read-modify-write sequences.
- Error flags: cl_timeout_err_o[i] stays set until err_clear_i[i]. A set and a clear in the same cycle leaves the flag set.
- Reset mid-transaction forces IDLE immediately; a late core readdatavalid after reset is dropped.

Test Plan:
- NUM_CLIENTS=3; clients 0, 1 and 2 each issue a write at the same cycle -> core sees writes in order 0, 1, 2; each client's waitrequest falls only during its own acceptance cycle.
- Client 1 issues a read; core returns 16'hBEEF 5 cycles after acceptance -> cl_readdata_o = 16'hBEEF with cl_readdatavalid_o = 3'b010 for exactly 1 cycle; the other strobes stay 0.
- Client 0 holds lock across write, read, write while client 2 requests continuously -> core sees all three client-0 transactions back-to-back before client 2 is granted.
- RD_TIMEOUT_CYCLES=20; core never returns data for client 2's read -> after 20 cycles client 2 gets readdata 0 and a valid strobe, cl_timeout_err_o[2] = 1; err_clear_i[2] clears it next cycle.
- Core waitrequest held high for 10 cycles during client 1's write -> m_address_o and m_writedata_o are stable for all 10 cycles; acceptance occurs on cycle 11.
- srst_i asserted while in RDWAIT, with core readdatavalid arriving 2 cycles later -> no client strobe fires, all waitrequest outputs are 1, and client 0 has next priority.
